// File: rtl/rr_grant_encoder_pkg.sv
// ============================================================================
// Module  : rr_grant_encoder_pkg
// Brief   : Shared constants, FSM encoding and index helper for the arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package rr_grant_encoder_pkg;

  localparam int IDX_W = 3;
  localparam int N_REQ = 2 ** IDX_W;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // N_REQ is a power of two, so the natural IDX_W-bit wrap gives the modulo.
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    return idx + 1'b1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_grant_encoder_pick.sv
// ============================================================================
// Module  : rr_pick
// Brief   : Combinational round-robin winner search starting at i_ptr.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick
  import rr_grant_encoder_pkg::*;
(
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [IDX_W-1:0] o_winner,
  output logic             o_any_req
);

  logic [2*N_REQ-1:0] w_dbl;
  logic [N_REQ-1:0]   w_rot;
  logic [IDX_W-1:0]   w_off;

  // Rotating right by the pointer puts the highest-priority requester at bit 0.
  assign w_dbl = {i_req, i_req} >> i_ptr;
  assign w_rot = w_dbl[N_REQ-1:0];

  always_comb begin
    w_off = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        w_off = IDX_W'(i);
      end
    end
  end

  assign o_winner  = i_ptr + w_off;
  assign o_any_req = |i_req;

endmodule

`default_nettype wire

// File: rtl/rr_grant_encoder.sv
// ============================================================================
// Module  : rr_grant_encoder
// Brief   : 8-way round-robin arbiter with registered index/valid and hold limit.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_grant_encoder
  import rr_grant_encoder_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic [N_REQ-1:0] i_req,
  input  logic             i_release,
  output logic [IDX_W-1:0] o_gnt_idx,
  output logic             o_gnt_valid,
  output logic             o_timeout
);

  localparam int HOLD_W = $clog2(MAX_HOLD);
  localparam logic [HOLD_W-1:0] C_HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  state_t            r_state;
  logic [IDX_W-1:0]  r_ptr;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic [IDX_W-1:0]  r_gnt_idx;
  logic              r_gnt_valid;
  logic              r_timeout;
  logic [IDX_W-1:0]  w_winner;
  logic              w_any_req;

  rr_pick u_pick (
    .i_req     (i_req),
    .i_ptr     (r_ptr),
    .o_winner  (w_winner),
    .o_any_req (w_any_req)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_hold_cnt  <= '0;
      r_gnt_idx   <= '0;
      r_gnt_valid <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_en && w_any_req) begin
            r_gnt_idx   <= w_winner;
            r_gnt_valid <= 1'b1;
            r_hold_cnt  <= '0;
            r_state     <= GRANT;
          end else begin
            r_gnt_valid <= 1'b0;
          end
        end
        GRANT: begin
          // Release and request drop outrank the hold limit, suppressing timeout.
          if (i_release || !i_req[r_gnt_idx]) begin
            r_gnt_valid <= 1'b0;
            r_ptr       <= next_idx(r_gnt_idx);
            r_state     <= IDLE;
          end else if (r_hold_cnt == C_HOLD_LAST) begin
            r_gnt_valid <= 1'b0;
            r_timeout   <= 1'b1;
            r_ptr       <= next_idx(r_gnt_idx);
            r_state     <= IDLE;
          end else begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_gnt_idx   = r_gnt_idx;
  assign o_gnt_valid = r_gnt_valid;
  assign o_timeout   = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_rr_grant_encoder.sv
// ============================================================================
// Module  : tb_rr_grant_encoder
// Brief   : Directed self-checking bench for rr_grant_encoder.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rr_grant_encoder;

  logic       clk;
  logic       rst_n;
  logic       i_en;
  logic [7:0] i_req;
  logic       i_release;
  logic [2:0] o_gnt_idx;
  logic       o_gnt_valid;
  logic       o_timeout;

  int checks = 0;
  int errors = 0;

  rr_grant_encoder #(.MAX_HOLD(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_en        (i_en),
    .i_req       (i_req),
    .i_release   (i_release),
    .o_gnt_idx   (o_gnt_idx),
    .o_gnt_valid (o_gnt_valid),
    .o_timeout   (o_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expect a live grant to idx with no timeout pulse.
  task automatic chk_grant(input string tag, input logic [2:0] idx);
    chk({tag, "_valid"}, {7'd0, o_gnt_valid}, 8'd1);
    chk({tag, "_idx"}, {5'd0, o_gnt_idx}, {5'd0, idx});
    chk({tag, "_to"}, {7'd0, o_timeout}, 8'd0);
  endtask

  task automatic chk_idle(input string tag, input logic to_exp);
    chk({tag, "_valid"}, {7'd0, o_gnt_valid}, 8'd0);
    chk({tag, "_to"}, {7'd0, o_timeout}, {7'd0, to_exp});
  endtask

  initial begin
    rst_n = 1'b0; i_en = 1'b1; i_req = 8'hFF; i_release = 1'b0;
    tick();
    tick();
    chk_idle("reset", 1'b0);
    chk("reset_idx", {5'd0, o_gnt_idx}, 8'd0);

    // First grant one edge after reset deasserts.
    rst_n = 1'b1;
    tick();
    chk_grant("first", 3'd0);
    i_release = 1'b1;
    tick();
    i_release = 1'b0;
    chk_idle("first_rel", 1'b0);

    // Rotation through all requesters with an idle cycle between grants.
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk_grant("rot", 3'(k % 8));
      i_release = 1'b1;
      tick();
      i_release = 1'b0;
      chk_idle("rot_gap", 1'b0);
    end

    // Single requester 5, released on the fourth grant cycle; ptr is 1 here.
    i_req = 8'b0010_0000;
    tick();
    chk_grant("single", 3'd5);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_grant("single_hold", 3'd5);
    end
    i_release = 1'b1;
    tick();
    i_release = 1'b0;
    chk_idle("single_rel", 1'b0);

    // ptr should now be 6.
    i_req = 8'hFF;
    tick();
    chk_grant("ptr6", 3'd6);
    i_release = 1'b1;
    tick();
    i_release = 1'b0;
    chk_idle("ptr6_rel", 1'b0);

    // Wrap: ptr=7 picks 7 over 0; dropping req[7] ends the grant, then 0 wins.
    i_req = 8'b1000_0001;
    tick();
    chk_grant("wrap", 3'd7);
    i_req = 8'b0000_0001;
    tick();
    chk_idle("drop", 1'b0);
    tick();
    chk_grant("wrap_next", 3'd0);
    i_release = 1'b1;
    tick();
    i_release = 1'b0;
    chk_idle("wrap_rel", 1'b0);

    // Timeout: ptr=1, requester 3 held with no release.
    i_req = 8'b0000_1000;
    tick();
    chk_grant("to_start", 3'd3);
    for (int k = 0; k < 15; k++) begin
      tick();
      chk_grant("to_hold", 3'd3);
    end
    tick();
    chk_idle("to_end", 1'b1);
    tick();
    chk_grant("to_regrant", 3'd3);
    i_release = 1'b1;
    tick();
    i_release = 1'b0;
    chk_idle("to_rel", 1'b0);

    // en=0 blocks arbitration; raising it grants next edge.
    i_en = 1'b0;
    i_req = 8'h10;
    tick();
    tick();
    chk_idle("en_low", 1'b0);
    i_en = 1'b1;
    tick();
    chk_grant("en_high", 3'd4);
    i_en = 1'b0;
    tick();
    chk_grant("en_in_grant", 3'd4);

    // Reset in the middle of a grant.
    rst_n = 1'b0;
    tick();
    chk_idle("mid_rst", 1'b0);
    chk("mid_rst_idx", {5'd0, o_gnt_idx}, 8'd0);
    rst_n = 1'b1;
    i_req = 8'h00;
    i_en = 1'b1;
    tick();
    chk_idle("post_rst", 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
